// File: rtl/video_sync_seq.sv
// video_sync_seq: raster timing sequencer for the video sync path.
// Owns the pixel (hcnt) and line (vcnt) counters, steps the horizontal and
// vertical ACT/FP/SYNC/BP phase machines, and drives registered sync, blank
// and line/frame strobes that are cycle-aligned with the counters.
//
// Alignment scheme: every output register is loaded from the *next* counter
// and phase values (_d), so the outputs visible in a cycle always describe
// the hcnt/vcnt visible in that same cycle.

module video_sync_seq #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int HW     = 10,
  parameter int VW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          hsync_n_o,
  output logic          vsync_n_o,
  output logic          csync_n_o,
  output logic          cblank_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  // --------------------------------------------------------------------------
  // Derived timing constants
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  // First pixel/line of each phase; phase changes are detected by exact
  // equality of the next counter value against these.
  localparam logic [HW-1:0] H_FP_START   = HW'(H_ACT);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_BP_START   = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);

  localparam logic [VW-1:0] V_FP_START   = VW'(V_ACT);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_BP_START   = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (H_ACT < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_hphase
      $error("video_sync_seq: every horizontal phase must be at least one pixel wide");
    end
    if (V_ACT < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_vphase
      $error("video_sync_seq: every vertical phase must be at least one line wide");
    end
    if (HW < 1 || HW > 30 || (H_TOTAL - 1) >= (1 << HW)) begin : g_bad_hw
      $error("video_sync_seq: HW too narrow to hold H_TOTAL-1");
    end
    if (VW < 1 || VW > 30 || (V_TOTAL - 1) >= (1 << VW)) begin : g_bad_vw
      $error("video_sync_seq: VW too narrow to hold V_TOTAL-1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Phase encoding shared by both machines. All four 2-bit codes are legal;
  // the default arms below still force ACT so a corrupted register recovers.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  phase_e        hstate_q, hstate_d;
  phase_e        vstate_q, vstate_d;

  logic hsync_n_q, hsync_n_d;
  logic vsync_n_q, vsync_n_d;
  logic csync_n_q, csync_n_d;
  logic cblank_q, cblank_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  logic h_wrap;     // current pixel is the last of the line
  logic v_wrap;     // current line is the last of the frame
  logic advance;    // counters step this edge (enabled and not restarting)
  logic line_step;  // pixel counter wraps this edge, so the line counter steps

  assign h_wrap    = (hcnt_q == H_LAST);
  assign v_wrap    = (vcnt_q == V_LAST);
  assign advance   = en_i & ~clr_i;
  assign line_step = advance & h_wrap;

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------

  // Next pixel/line position: restart on clr, step on en, otherwise hold.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (clr_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (en_i) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Horizontal and vertical phase machines
  // --------------------------------------------------------------------------

  // Phase state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hstate_q <= PH_ACT;
      vstate_q <= PH_ACT;
    end else begin
      hstate_q <= hstate_d;
      vstate_q <= vstate_d;
    end
  end

  // Horizontal next phase, keyed on the pixel index being entered.
  always_comb begin
    hstate_d = hstate_q;
    if (clr_i) begin
      hstate_d = PH_ACT;
    end else if (en_i) begin
      case (hstate_q)
        PH_ACT:  if (hcnt_d == H_FP_START)   hstate_d = PH_FP;
        PH_FP:   if (hcnt_d == H_SYNC_START) hstate_d = PH_SYNC;
        PH_SYNC: if (hcnt_d == H_BP_START)   hstate_d = PH_BP;
        PH_BP:   if (hcnt_d == '0)           hstate_d = PH_ACT;
        default:                             hstate_d = PH_ACT;
      endcase
    end
  end

  // Vertical next phase; moves only when the line counter steps.
  always_comb begin
    vstate_d = vstate_q;
    if (clr_i) begin
      vstate_d = PH_ACT;
    end else if (line_step) begin
      case (vstate_q)
        PH_ACT:  if (vcnt_d == V_FP_START)   vstate_d = PH_FP;
        PH_FP:   if (vcnt_d == V_SYNC_START) vstate_d = PH_SYNC;
        PH_SYNC: if (vcnt_d == V_BP_START)   vstate_d = PH_BP;
        PH_BP:   if (vcnt_d == '0)           vstate_d = PH_ACT;
        default:                             vstate_d = PH_ACT;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sync, blank and strobe outputs
  // --------------------------------------------------------------------------

  // Output decode from the phases being entered, so outputs track the counters.
  // Composite sync XORs the two active syncs, which serrates it during vsync.
  always_comb begin
    logic hsync_act;
    logic vsync_act;
    hsync_act     = (hstate_d == PH_SYNC);
    vsync_act     = (vstate_d == PH_SYNC);
    hsync_n_d     = ~hsync_act;
    vsync_n_d     = ~vsync_act;
    csync_n_d     = ~(hsync_act ^ vsync_act);
    cblank_d      = (hstate_d != PH_ACT) | (vstate_d != PH_ACT);
    line_start_d  = line_step;
    frame_start_d = line_step & v_wrap;
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      csync_n_q     <= 1'b1;
      cblank_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      csync_n_q     <= csync_n_d;
      cblank_q      <= cblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign hsync_n_o     = hsync_n_q;
  assign vsync_n_o     = vsync_n_q;
  assign csync_n_o     = csync_n_q;
  assign cblank_o      = cblank_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule
